// File: rtl/seg7_scan_multi.sv
// Time-multiplexed seven-segment driver with source select, snapshot/freeze,
// leading-zero blanking, per-digit decimal points and per-digit blinking.
// A two-stage output pipeline keeps the anode and segment outputs aligned.
module seg7_scan_multi #(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned SRC        = 3,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned SCAN_BITS  = 10,
    parameter int unsigned BLINK_BITS = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SRC*DIGITS*4-1:0]   src_data,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic                      freeze,
    input  logic                      blank_lz,
    input  logic [DIGITS-1:0]         dp_mask,
    input  logic [DIGITS-1:0]         blink_mask,
    output logic [DIGITS-1:0]         digit_anode,
    output logic [7:0]                segment
);

    localparam int unsigned NUM_W = DIGITS * 4;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [NUM_W-1:0]      src_word_c;
    logic [NUM_W-1:0]      disp_num;
    logic [SCAN_BITS-1:0]  pre;
    logic [IDX_W-1:0]      idx;
    logic [BLINK_BITS-1:0] blink_cnt;

    logic [3:0]            nib_c;
    logic                  blink_en_c;
    logic                  upper_nz_c;
    logic                  blank_c;

    logic [IDX_W-1:0]      idx_q;
    logic [3:0]            nib;
    logic                  blank;

    logic [DIGITS-1:0]     anode_c;
    logic                  dp_c;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    endfunction

    // Source word mux; out-of-range selects yield zero.
    always_comb begin
        src_word_c = '0;
        for (int unsigned s = 0; s < SRC; s++) begin
            if (32'(src_sel) == s) begin
                src_word_c = src_data[s*NUM_W +: NUM_W];
            end
        end
    end

    // Snapshot register, held while frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_num <= '0;
        end else if (!freeze) begin
            disp_num <= src_word_c;
        end
    end

    // Scan prescaler and digit index (wraps at DIGITS-1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else begin
            pre <= pre + SCAN_BITS'(1);
            if (&pre) begin
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Free-running blink counter; its MSB is the blink phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + BLINK_BITS'(1);
        end
    end

    // Current nibble and blank decision (leading zeros at or above idx, or blink).
    always_comb begin
        nib_c      = '0;
        blink_en_c = 1'b0;
        upper_nz_c = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (32'(idx) == i) begin
                nib_c      = disp_num[i*4 +: 4];
                blink_en_c = blink_mask[i];
            end
            if ((i >= 32'(idx)) && (disp_num[i*4 +: 4] != 4'h0)) begin
                upper_nz_c = 1'b1;
            end
        end
        blank_c = (blank_lz && (idx != '0) && !upper_nz_c)
                || (blink_en_c && blink_cnt[BLINK_BITS-1]);
    end

    // Stage 1 pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            nib   <= '0;
            blank <= 1'b0;
        end else begin
            idx_q <= idx;
            nib   <= nib_c;
            blank <= blank_c;
        end
    end

    // One-hot-low anode and decimal point for the stage-1 digit.
    always_comb begin
        anode_c = '1;
        dp_c    = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (32'(idx_q) == i) begin
                anode_c[i] = 1'b0;
                dp_c       = dp_mask[i];
            end
        end
    end

    // Stage 2: registered pin outputs, anode and segments updated together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_anode <= '1;
            segment     <= 8'hFF;
        end else if (blank) begin
            digit_anode <= '1;
            segment     <= 8'hFF;
        end else begin
            digit_anode <= anode_c;
            segment     <= {~dp_c, hex_seg(nib)};
        end
    end

endmodule

// File: tb/tb_seg7_scan_multi.sv
// Self-checking bench for seg7_scan_multi: 8-digit, 5-digit and 1-digit instances.
module tb_seg7_scan_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-digit instance
    logic        rst;
    logic [95:0] src8;
    logic [1:0]  sel8;
    logic        frz8, lz8;
    logic [7:0]  dp8, bl8, an8, seg8;

    // 5-digit instance
    logic        rst5;
    logic [39:0] src5;
    logic [0:0]  sel5;
    logic        frz5, lz5;
    logic [4:0]  dp5, bl5, an5;
    logic [7:0]  seg5;

    // 1-digit instance
    logic [3:0]  src1;
    logic [0:0]  sel1;
    logic        frz1, lz1;
    logic [0:0]  dp1, bl1, an1;
    logic [7:0]  seg1;

    seg7_scan_multi #(.DIGITS(8), .SRC(3), .SEL_W(2), .SCAN_BITS(2), .BLINK_BITS(4)) u_dut8 (
        .clk(clk), .rst(rst), .src_data(src8), .src_sel(sel8), .freeze(frz8),
        .blank_lz(lz8), .dp_mask(dp8), .blink_mask(bl8),
        .digit_anode(an8), .segment(seg8));

    seg7_scan_multi #(.DIGITS(5), .SRC(2), .SEL_W(1), .SCAN_BITS(2), .BLINK_BITS(4)) u_dut5 (
        .clk(clk), .rst(rst5), .src_data(src5), .src_sel(sel5), .freeze(frz5),
        .blank_lz(lz5), .dp_mask(dp5), .blink_mask(bl5),
        .digit_anode(an5), .segment(seg5));

    seg7_scan_multi #(.DIGITS(1), .SRC(1), .SEL_W(1), .SCAN_BITS(2), .BLINK_BITS(4)) u_dut1 (
        .clk(clk), .rst(rst), .src_data(src1), .src_sel(sel1), .freeze(frz1),
        .blank_lz(lz1), .dp_mask(dp1), .blink_mask(bl1),
        .digit_anode(an1), .segment(seg1));

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 8'hC0;  4'h1: seg_of = 8'hF9;
            4'h2: seg_of = 8'hA4;  4'h3: seg_of = 8'hB0;
            4'h4: seg_of = 8'h99;  4'h5: seg_of = 8'h92;
            4'h6: seg_of = 8'h82;  4'h7: seg_of = 8'hF8;
            4'h8: seg_of = 8'h80;  4'h9: seg_of = 8'h90;
            4'hA: seg_of = 8'h88;  4'hB: seg_of = 8'h83;
            4'hC: seg_of = 8'hC6;  4'hD: seg_of = 8'hA1;
            4'hE: seg_of = 8'h86;  default: seg_of = 8'h8E;
        endcase
    endfunction

    // Queue one 8-digit frame, 4 cycles per digit, no blanking.
    task automatic push_frame8(input logic [31:0] val, input logic [7:0] dp);
        exp_t       e;
        logic [7:0] s;
        for (int d = 0; d < 8; d++) begin
            s = seg_of(val[d*4 +: 4]);
            for (int c = 0; c < 4; c++) begin
                e.an  = ~(8'h01 << d);
                e.seg = {~dp[d], s[6:0]};
                q.push_back(e);
            end
        end
    endtask

    task automatic push_digit(input logic [7:0] an, input logic [7:0] sg, input int n);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            e.an  = an;
            e.seg = sg;
            q.push_back(e);
        end
    endtask

    // Stop on the first sample of digit 0 following another digit or blank.
    task automatic sync8(output bit ok);
        logic [7:0] prev;
        ok   = 1'b0;
        prev = an8;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (an8 == 8'hFE && prev != 8'hFE) begin
                ok = 1'b1;
                return;
            end
            prev = an8;
        end
    endtask

    task automatic sync5(output bit ok);
        logic [4:0] prev;
        ok   = 1'b0;
        prev = an5;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (an5 == 5'h1E && prev != 5'h1E) begin
                ok = 1'b1;
                return;
            end
            prev = an5;
        end
    endtask

    // Stop on the first blank sample after a visible one.
    task automatic sync1(output bit ok);
        logic [0:0] prev;
        ok   = 1'b0;
        prev = an1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (an1 == 1'b1 && prev == 1'b0) begin
                ok = 1'b1;
                return;
            end
            prev = an1;
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        rst5 = 1'b1;
        src8 = {32'h13579BDF, 32'h00000001, 32'h89ABCDEF};
        sel8 = 2'd0; frz8 = 1'b0; lz8 = 1'b0; dp8 = 8'h00; bl8 = 8'h00;
        src5 = {20'h00000, 20'h43210};
        sel5 = 1'b0; frz5 = 1'b0; lz5 = 1'b0; dp5 = 5'h00; bl5 = 5'h00;
        src1 = 4'h5; sel1 = 1'b0; frz1 = 1'b0; lz1 = 1'b0; dp1 = 1'b0; bl1 = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (an8 !== 8'hFF || seg8 !== 8'hFF) begin
            bad++;
            $display("FAIL reset8: anode=%h segment=%h required FF/FF", an8, seg8);
        end
        total++;
        if (an5 !== 5'h1F || seg5 !== 8'hFF || an1 !== 1'b1 || seg1 !== 8'hFF) begin
            bad++;
            $display("FAIL reset5_1: an5=%h seg5=%h an1=%h seg1=%h required 1F/FF/1/FF",
                     an5, seg5, an1, seg1);
        end
        rst  = 1'b0;
        rst5 = 1'b0;
        @(negedge clk);
        total++;
        if (an8 !== 8'hFE) begin
            bad++;
            $display("FAIL reset_first_digit: anode=%h required FE", an8);
        end
    endtask

    task automatic test_scan;
        bit   ok;
        exp_t e;
        push_frame8(32'h89ABCDEF, 8'h00);
        repeat (4) @(negedge clk);
        sync8(ok);
        total++;
        if (!ok) begin
            bad++; q.delete();
            $display("FAIL scan_sync: digit 0 not found within bound");
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (an8 !== e.an || seg8 !== e.seg) begin
                bad++;
                $display("FAIL scan: anode=%h segment=%h required %h/%h", an8, seg8, e.an, e.seg);
            end
            @(negedge clk);
        end
        total++;
        if (an8 !== 8'hFE || seg8 !== 8'h8E) begin
            bad++;
            $display("FAIL scan_wrap: anode=%h segment=%h required FE/8E", an8, seg8);
        end
    endtask

    task automatic test_src_sel;
        bit         ok;
        exp_t       e;
        logic [7:0] want;
        sync8(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL sel_sync: digit 0 not found within bound");
        end
        sel8 = 2'd1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            want = (k == 3) ? 8'hF9 : 8'h8E;
            total++;
            if (an8 !== 8'hFE || seg8 !== want) begin
                bad++;
                $display("FAIL sel_latency k=%0d: anode=%h segment=%h required FE/%h", k, an8, seg8, want);
            end
        end
        for (int p = 0; p < 3; p++) begin
            case (p)
                0: push_frame8(32'h00000001, 8'h00);
                1: begin sel8 = 2'd2; push_frame8(32'h13579BDF, 8'h00); end
                default: begin sel8 = 2'd3; push_frame8(32'h00000000, 8'h00); end
            endcase
            repeat (4) @(negedge clk);
            sync8(ok);
            total++;
            if (!ok) begin
                bad++; q.delete();
                $display("FAIL sel_frame_sync p=%0d: digit 0 not found", p);
            end
            while (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (an8 !== e.an || seg8 !== e.seg) begin
                    bad++;
                    $display("FAIL sel_frame p=%0d: anode=%h segment=%h required %h/%h",
                             p, an8, seg8, e.an, e.seg);
                end
                @(negedge clk);
            end
        end
        sel8 = 2'd0;
    endtask

    task automatic test_lz;
        bit   ok;
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            if (p == 0) begin
                src8[31:0] = 32'h00000120;
                push_digit(8'hFE, 8'hC0, 4);
                push_digit(8'hFD, 8'hA4, 4);
                push_digit(8'hFB, 8'hF9, 4);
                push_digit(8'hFF, 8'hFF, 20);
            end else begin
                src8[31:0] = 32'h00000000;
                push_digit(8'hFE, 8'hC0, 4);
                push_digit(8'hFF, 8'hFF, 28);
            end
            lz8 = 1'b1;
            repeat (4) @(negedge clk);
            sync8(ok);
            total++;
            if (!ok) begin
                bad++; q.delete();
                $display("FAIL lz_sync p=%0d: digit 0 not found", p);
            end
            while (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (an8 !== e.an || seg8 !== e.seg) begin
                    bad++;
                    $display("FAIL lz p=%0d: anode=%h segment=%h required %h/%h",
                             p, an8, seg8, e.an, e.seg);
                end
                @(negedge clk);
            end
        end
        lz8 = 1'b0;
        src8[31:0] = 32'h89ABCDEF;
    endtask

    task automatic test_dp_blink;
        bit   ok;
        exp_t e;
        dp8 = 8'h04;
        push_frame8(32'h89ABCDEF, 8'h04);
        repeat (4) @(negedge clk);
        sync8(ok);
        total++;
        if (!ok) begin
            bad++; q.delete();
            $display("FAIL dp_sync: digit 0 not found");
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (an8 !== e.an || seg8 !== e.seg) begin
                bad++;
                $display("FAIL dp: anode=%h segment=%h required %h/%h", an8, seg8, e.an, e.seg);
            end
            @(negedge clk);
        end
        dp8 = 8'h00;

        // Single-digit instance: digit 0 alternates 8 blank / 8 visible cycles.
        bl1 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push_digit(8'h01, 8'hFF, 8);
            push_digit(8'h00, 8'h92, 8);
        end
        repeat (4) @(negedge clk);
        sync1(ok);
        total++;
        if (!ok) begin
            bad++; q.delete();
            $display("FAIL blink_sync: blank edge not found");
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (an1 !== e.an[0] || seg1 !== e.seg) begin
                bad++;
                $display("FAIL blink: anode=%h segment=%h required %h/%h", an1, seg1, e.an[0], e.seg);
            end
            @(negedge clk);
        end
        bl1 = 1'b0;
    endtask

    task automatic test_freeze;
        bit         ok;
        exp_t       e;
        logic [7:0] want;
        src8[31:0] = 32'h12345678;
        repeat (4) @(negedge clk);
        frz8       = 1'b1;
        src8[31:0] = 32'hFFFFFFFF;
        push_frame8(32'h12345678, 8'h00);
        repeat (4) @(negedge clk);
        sync8(ok);
        total++;
        if (!ok) begin
            bad++; q.delete();
            $display("FAIL freeze_sync: digit 0 not found");
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (an8 !== e.an || seg8 !== e.seg) begin
                bad++;
                $display("FAIL freeze_hold: anode=%h segment=%h required %h/%h", an8, seg8, e.an, e.seg);
            end
            @(negedge clk);
        end
        sync8(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL freeze_rel_sync: digit 0 not found");
        end
        frz8 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            want = (k == 3) ? 8'h8E : 8'h80;
            total++;
            if (an8 !== 8'hFE || seg8 !== want) begin
                bad++;
                $display("FAIL freeze_release k=%0d: anode=%h segment=%h required FE/%h", k, an8, seg8, want);
            end
        end
        push_frame8(32'hFFFFFFFF, 8'h00);
        sync8(ok);
        total++;
        if (!ok) begin
            bad++; q.delete();
            $display("FAIL freeze_frame_sync: digit 0 not found");
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (an8 !== e.an || seg8 !== e.seg) begin
                bad++;
                $display("FAIL freeze_frame: anode=%h segment=%h required %h/%h", an8, seg8, e.an, e.seg);
            end
            @(negedge clk);
        end
        src8[31:0] = 32'h89ABCDEF;
    endtask

    task automatic test_depth5;
        bit         ok;
        exp_t       e;
        logic [7:0] s;
        for (int d = 0; d < 5; d++) begin
            s = seg_of(4'(d));
            push_digit({3'b000, ~(5'h01 << d)}, s, 4);
        end
        sync5(ok);
        total++;
        if (!ok) begin
            bad++; q.delete();
            $display("FAIL d5_sync: digit 0 not found");
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (an5 !== e.an[4:0] || seg5 !== e.seg) begin
                bad++;
                $display("FAIL d5_scan: anode=%h segment=%h required %h/%h", an5, seg5, e.an[4:0], e.seg);
            end
            @(negedge clk);
        end
        total++;
        if (an5 !== 5'h1E || seg5 !== 8'hC0) begin
            bad++;
            $display("FAIL d5_wrap: anode=%h segment=%h required 1E/C0", an5, seg5);
        end

        // Asynchronous reset while digit 3 is lit.
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (an5 == 5'h17) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL d5_digit3: digit 3 not found within bound");
        end
        #2;
        rst5 = 1'b1;
        #1;
        total++;
        if (an5 !== 5'h1F || seg5 !== 8'hFF) begin
            bad++;
            $display("FAIL d5_async_rst: anode=%h segment=%h required 1F/FF", an5, seg5);
        end
        @(negedge clk);
        rst5 = 1'b0;
        @(negedge clk);
        total++;
        if (an5 !== 5'h1E) begin
            bad++;
            $display("FAIL d5_restart: anode=%h required 1E", an5);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_src_sel();
        test_lz();
        test_dp_blink();
        test_freeze();
        test_depth5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
